// File: rtl/ring_token_sched.sv
// rtl/ring_token_sched.sv - token ring lap scheduler with return-beat checking and round-trip latency
module ring_token_sched #(
  parameter int N_LINK  = 4,
  parameter int HOP_INC = 1,
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [7:0]  i_laps,
  input  logic [31:0] i_seed,
  output logic        o_wen,
  output logic [31:0] o_token,
  output logic [31:0] o_clk_cnt,
  output logic [31:0] o_id,
  input  logic        i_wen,
  input  logic [31:0] i_token,
  input  logic [31:0] i_clk_cnt,
  input  logic [31:0] i_id,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic [7:0]  o_lap_cnt,
  output logic [31:0] o_last_lat
);

  localparam logic [31:0] LP_N_LINK   = 32'(N_LINK);
  localparam logic [31:0] LP_ID_LAST  = 32'(N_LINK - 1);
  localparam logic [31:0] LP_RING_INC = 32'(N_LINK * HOP_INC);
  localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] LP_ERR_NONE = 2'd0;
  localparam logic [1:0] LP_ERR_TMO  = 2'd1;
  localparam logic [1:0] LP_ERR_TOK  = 2'd2;
  localparam logic [1:0] LP_ERR_ID   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INJECT,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_cyc;
  logic [15:0] r_timer;
  logic [7:0]  r_laps;
  logic [31:0] r_seed;
  logic [7:0]  r_lap_cnt;
  logic [31:0] r_expected;
  logic [31:0] r_token;
  logic [31:0] r_clk_cnt;
  logic [31:0] r_id;
  logic [1:0]  r_err_code;
  logic [31:0] r_last_lat;

  logic        w_start_ok;
  logic [31:0] w_inj_token;
  logic        w_id_bad;
  logic        w_tok_bad;
  logic [7:0]  w_lap_next;
  logic        w_timeout;
  logic [1:0]  w_err_code;
  logic        w_beat_ok;

  assign w_start_ok  = i_start && (i_laps != 8'd0);
  assign w_inj_token = r_seed + {24'd0, r_lap_cnt};
  assign w_id_bad    = (i_id != LP_ID_LAST);
  assign w_tok_bad   = (i_token != r_expected);
  assign w_lap_next  = r_lap_cnt + 8'd1;
  // Timer is about to reach TIMEOUT on this edge; a beat in the same cycle still wins.
  assign w_timeout   = (r_timer == LP_TMO_LAST);

  always_comb begin
    w_next     = r_state;
    w_err_code = r_err_code;
    w_beat_ok  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next = S_INJECT;
        end
      end
      S_INJECT: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_wen) begin
          if (w_id_bad) begin
            w_next     = S_ERR;
            w_err_code = LP_ERR_ID;
          end else if (w_tok_bad) begin
            w_next     = S_ERR;
            w_err_code = LP_ERR_TOK;
          end else begin
            w_beat_ok = 1'b1;
            w_next    = (w_lap_next == r_laps) ? S_DONE : S_INJECT;
          end
        end else if (w_timeout) begin
          w_next     = S_ERR;
          w_err_code = LP_ERR_TMO;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      S_ERR: begin
        w_next = S_ERR;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (i_abort) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cyc      <= 32'd0;
      r_timer    <= 16'd0;
      r_laps     <= 8'd0;
      r_seed     <= 32'd0;
      r_lap_cnt  <= 8'd0;
      r_expected <= 32'd0;
      r_token    <= 32'd0;
      r_clk_cnt  <= 32'd0;
      r_id       <= 32'd0;
      r_err_code <= LP_ERR_NONE;
      r_last_lat <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cyc   <= r_cyc + 32'd1;

      if ((r_state == S_WAIT) && (w_next == S_WAIT)) begin
        r_timer <= r_timer + 16'd1;
      end else begin
        r_timer <= 16'd0;
      end

      // The injected beat has already left on the wire, so its hold copy is kept even under abort.
      if (r_state == S_INJECT) begin
        r_token    <= w_inj_token;
        r_clk_cnt  <= r_cyc;
        r_id       <= LP_N_LINK;
        r_expected <= w_inj_token + LP_RING_INC;
      end

      if (!i_abort) begin
        if ((r_state == S_IDLE) && w_start_ok) begin
          r_laps     <= i_laps;
          r_seed     <= i_seed;
          r_lap_cnt  <= 8'd0;
          r_err_code <= LP_ERR_NONE;
        end
        if (r_state == S_WAIT) begin
          r_err_code <= w_err_code;
          if (i_wen) begin
            r_last_lat <= r_cyc - i_clk_cnt;
          end
          if (w_beat_ok) begin
            r_lap_cnt <= w_lap_next;
          end
        end
      end
    end
  end

  assign o_wen      = (r_state == S_INJECT);
  assign o_token    = o_wen ? w_inj_token : r_token;
  assign o_clk_cnt  = o_wen ? r_cyc : r_clk_cnt;
  assign o_id       = o_wen ? LP_N_LINK : r_id;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_err      = (r_state == S_ERR);
  assign o_err_code = r_err_code;
  assign o_lap_cnt  = r_lap_cnt;
  assign o_last_lat = r_last_lat;

endmodule

// File: tb/tb_ring_token_sched.sv
// tb/tb_ring_token_sched.sv - directed bench for ring_token_sched with a configurable loopback ring
module tb_ring_token_sched;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [7:0]  i_laps = 8'd0;
  logic [31:0] i_seed = 32'd0;
  logic        o_wen;
  logic [31:0] o_token;
  logic [31:0] o_clk_cnt;
  logic [31:0] o_id;
  logic        i_wen = 1'b0;
  logic [31:0] i_token = 32'd0;
  logic [31:0] i_clk_cnt = 32'd0;
  logic [31:0] i_id = 32'd0;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic [7:0]  o_lap_cnt;
  logic [31:0] o_last_lat;

  ring_token_sched #(.N_LINK(4), .HOP_INC(1), .TIMEOUT(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_laps(i_laps), .i_seed(i_seed),
    .o_wen(o_wen), .o_token(o_token), .o_clk_cnt(o_clk_cnt), .o_id(o_id),
    .i_wen(i_wen), .i_token(i_token), .i_clk_cnt(i_clk_cnt), .i_id(i_id),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code),
    .o_lap_cnt(o_lap_cnt), .o_last_lat(o_last_lat)
  );

  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_miss = 0;
  int n_done = 0;

  logic [31:0] tb_cyc = 32'd0;
  always @(posedge i_clk) begin
    if (i_rst) tb_cyc <= 32'd0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  // Loopback ring model: returns each injected beat after lb_delay cycles.
  logic        lb_en = 1'b0;
  int          lb_delay = 5;
  logic [31:0] lb_add = 32'd4;
  logic [31:0] lb_id = 32'd3;
  logic        lb_force = 1'b0;
  logic [31:0] lb_forge = 32'd0;
  int          lb_cnt = 0;
  logic [31:0] lb_tok = 32'd0;
  logic [31:0] lb_clk = 32'd0;
  logic [31:0] lb_ret_cyc = 32'd0;
  logic [31:0] inj_tok[$];
  logic [31:0] inj_clk[$];
  logic [31:0] inj_cyc[$];

  always @(negedge i_clk) begin
    i_wen = 1'b0;
    if (lb_cnt > 0) begin
      lb_cnt--;
      if (lb_cnt == 0) begin
        i_wen      = 1'b1;
        i_token    = lb_tok + lb_add;
        i_clk_cnt  = lb_force ? lb_forge : lb_clk;
        i_id       = lb_id;
        lb_ret_cyc = tb_cyc;
      end
    end
    if (o_wen) begin
      inj_tok.push_back(o_token);
      inj_clk.push_back(o_clk_cnt);
      inj_cyc.push_back(tb_cyc);
      if (lb_en) begin
        lb_cnt = lb_delay;
        lb_tok = o_token;
        lb_clk = o_clk_cnt;
      end
    end
    if (o_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [7:0] laps, input logic [31:0] seed);
    @(negedge i_clk);
    i_start = 1'b1;
    i_laps  = laps;
    i_seed  = seed;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int max);
    int n = 0;
    while (o_busy && !o_err && n < max) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, {31'd0, n >= max}, 32'd0);
  endtask

  task automatic wait_lap(input string tag, input logic [7:0] v, input int max);
    int n = 0;
    while (o_lap_cnt != v && n < max) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, {31'd0, n >= max}, 32'd0);
  endtask

  task automatic pulse_abort();
    @(negedge i_clk);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int base;
    int d0;
    int j;
    logic [31:0] exp_lat;

    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_wen", {31'd0, o_wen}, 32'd0);
    chk("rst_token", o_token, 32'd0);
    chk("rst_lap", {24'd0, o_lap_cnt}, 32'd0);
    chk("rst_err", {29'd0, o_err, o_err_code}, 32'd0);

    // Clean 3-lap run with an ignored second start.
    lb_en = 1'b1; lb_delay = 5; lb_add = 32'd4; lb_id = 32'd3;
    base = inj_tok.size(); d0 = n_done;
    start_run(8'd3, 32'h10);
    repeat (3) @(negedge i_clk);
    start_run(8'd1, 32'h99);
    wait_end("clean_bound", 200);
    repeat (5) @(negedge i_clk);
    chk("clean_ninj", inj_tok.size() - base, 32'd3);
    chk("clean_tok0", inj_tok[base], 32'h10);
    chk("clean_tok1", inj_tok[base+1], 32'h11);
    chk("clean_tok2", inj_tok[base+2], 32'h12);
    chk("clean_clkcnt", inj_clk[base], inj_cyc[base]);
    chk("clean_lap", {24'd0, o_lap_cnt}, 32'd3);
    chk("clean_lat", o_last_lat, 32'd5);
    chk("clean_done", n_done - d0, 32'd1);
    chk("clean_err", {31'd0, o_err}, 32'd0);

    // Timeout: ERR exactly 64 cycles after WAIT entry.
    lb_en = 1'b0;
    start_run(8'd1, 32'h1);
    chk("tmo_inject", {31'd0, o_wen}, 32'd1);
    j = 0;
    while (!o_err && j < 100) begin
      @(negedge i_clk);
      j++;
    end
    chk("tmo_cycles", j, 32'd65);
    chk("tmo_code", {30'd0, o_err_code}, 32'd1);
    start_run(8'd2, 32'h2);
    chk("err_sticky", {31'd0, o_err}, 32'd1);
    pulse_abort();
    chk("tmo_abort_busy", {31'd0, o_busy}, 32'd0);
    chk("tmo_abort_err", {31'd0, o_err}, 32'd0);

    // Token mismatch, then id mismatch with priority over token.
    lb_en = 1'b1; lb_add = 32'd3; lb_id = 32'd3;
    start_run(8'd2, 32'h5);
    wait_end("tokbad_bound", 100);
    chk("tokbad_code", {30'd0, o_err_code}, 32'd2);
    chk("tokbad_lap", {24'd0, o_lap_cnt}, 32'd0);
    pulse_abort();
    lb_id = 32'd2;
    start_run(8'd2, 32'h5);
    wait_end("idbad_bound", 100);
    chk("idbad_code", {30'd0, o_err_code}, 32'd3);
    chk("idbad_err", {31'd0, o_err}, 32'd1);
    pulse_abort();

    // Seed wrap: expected token wraps to 3.
    lb_add = 32'd4; lb_id = 32'd3; d0 = n_done;
    start_run(8'd1, 32'hFFFF_FFFF);
    wait_end("seedwrap_bound", 100);
    chk("seedwrap_done", n_done - d0, 32'd1);
    chk("seedwrap_err", {31'd0, o_err}, 32'd0);

    // Cycle-counter wrap between inject and return.
    lb_force = 1'b1; lb_forge = 32'hFFFF_FFFD;
    start_run(8'd1, 32'h20);
    wait_end("cycwrap_bound", 100);
    exp_lat = lb_ret_cyc - 32'hFFFF_FFFD;
    chk("cycwrap_lat", o_last_lat, exp_lat);
    lb_force = 1'b0;

    // Beat in the timeout cycle wins; one cycle later it is too late.
    lb_delay = 64; d0 = n_done;
    start_run(8'd1, 32'h30);
    wait_end("edge_bound", 200);
    chk("edge_done", n_done - d0, 32'd1);
    chk("edge_lat", o_last_lat, 32'd64);
    lb_delay = 65;
    start_run(8'd1, 32'h31);
    wait_end("late_bound", 200);
    chk("late_code", {29'd0, o_err, o_err_code}, 32'd5);
    repeat (3) @(negedge i_clk);
    pulse_abort();
    lb_delay = 5;

    // laps==0 and abort together with start are both no-ops from IDLE.
    base = inj_tok.size();
    start_run(8'd0, 32'h40);
    repeat (5) @(negedge i_clk);
    chk("laps0_busy", {31'd0, o_busy}, 32'd0);
    chk("laps0_ninj", inj_tok.size() - base, 32'd0);
    @(negedge i_clk);
    i_start = 1'b1; i_laps = 8'd2; i_abort = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_abort = 1'b0;
    chk("abst_busy", {31'd0, o_busy}, 32'd0);
    repeat (5) @(negedge i_clk);
    chk("abst_ninj", inj_tok.size() - base, 32'd0);

    // Abort mid-run keeps lap count and latency, no done.
    d0 = n_done;
    start_run(8'd3, 32'h40);
    wait_lap("abmid_bound", 8'd1, 100);
    @(negedge i_clk);
    i_abort = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0; i_start = 1'b0;
    chk("abmid_busy", {31'd0, o_busy}, 32'd0);
    repeat (10) @(negedge i_clk);
    chk("abmid_lap", {24'd0, o_lap_cnt}, 32'd1);
    chk("abmid_lat", o_last_lat, 32'd5);
    chk("abmid_done", n_done - d0, 32'd0);

    // Reset during lap 2 clears everything.
    start_run(8'd3, 32'h50);
    wait_lap("rstmid_bound", 8'd1, 100);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rstmid_busy", {31'd0, o_busy}, 32'd0);
    chk("rstmid_flags", {28'd0, o_wen, o_done, o_err, |o_err_code}, 32'd0);
    chk("rstmid_token", o_token, 32'd0);
    chk("rstmid_clkcnt", o_clk_cnt, 32'd0);
    chk("rstmid_id", o_id, 32'd0);
    chk("rstmid_lap", {24'd0, o_lap_cnt}, 32'd0);
    chk("rstmid_lat", o_last_lat, 32'd0);
    repeat (10) @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
